// File: rtl/gpu_host_port.sv
// Host bus register port: synchronises the cs_clock strobe, decodes register accesses and
// gives the host pointer-based auto-incrementing access to the video memories, plus IRQ logic.
module gpu_host_port #(
  parameter int NUM_MEM     = 3,
  parameter int ADDR_W      = 12,
  parameter int SCANLINE_W  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK100MHz,
  input  logic                    rst,
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic                    data_oe,
  input  logic [3:0]              addr,
  input  logic                    rw,
  input  logic                    cs_clock,
  input  logic [SCANLINE_W-1:0]   scanline,
  input  logic                    vblank,
  output logic [NUM_MEM-1:0]      mem_we,
  output logic [NUM_MEM-1:0]      mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_wdata,
  input  logic [NUM_MEM*8-1:0]    mem_rdata,
  output logic                    irq
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PREFETCH, S_WAIT} state_t;
  localparam logic [7:0] NUM_MEM_B = 8'(NUM_MEM);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    cs_prev_q;
  logic                    pend_v_q, pend_v_d, pend_rw_q, pend_rw_d;
  logic [3:0]              pend_addr_q, pend_addr_d;
  logic [7:0]              pend_data_q, pend_data_d;
  logic [1:0]              ctrl_q, ctrl_d, irqp_q, irqp_d;
  logic [SCANLINE_W-1:0]   line_q, line_d, scan_prev_q;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [2:0]              sel_q, sel_d;
  logic [7:0]              inc_q, inc_d, rdbuf_q, rdbuf_d, wdata_q, wdata_d, dout_q, dout_d;
  logic                    vb_prev_q, irq_q;

  logic       fire, take, a_rw;
  logic [3:0] a_addr;
  logic [7:0] a_data, rd_val, rdata_sel;
  logic [1:0] clr, set;
  logic [15:0] ptr_ext, line_ext;

  always_comb begin
    fire   = sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    take   = (state_q == S_IDLE) & (pend_v_q | fire);
    a_addr = pend_v_q ? pend_addr_q : addr;
    a_rw   = pend_v_q ? pend_rw_q   : rw;
    a_data = pend_v_q ? pend_data_q : data_in;
    ptr_ext  = 16'(ptr_q);
    line_ext = 16'(line_q);
    rdata_sel = '0;
    for (int i = 0; i < NUM_MEM; i++)
      if (sel_q == 3'(i)) rdata_sel = mem_rdata[i*8 +: 8];

    case (a_addr)
      4'd0:    rd_val = {6'd0, ctrl_q};
      4'd1:    rd_val = {vblank, 5'd0, irqp_q};
      4'd2:    rd_val = line_ext[7:0];
      4'd3:    rd_val = line_ext[15:8];
      4'd4:    rd_val = ptr_ext[7:0];
      4'd5:    rd_val = ptr_ext[15:8];
      4'd6:    rd_val = {5'd0, sel_q};
      4'd7:    rd_val = rdbuf_q;
      4'd8:    rd_val = inc_q;
      default: rd_val = 8'd0;
    endcase

    // 1-deep slot: refilled only when empty or being drained this same cycle
    pend_v_d = pend_v_q; pend_addr_d = pend_addr_q; pend_rw_d = pend_rw_q; pend_data_d = pend_data_q;
    if (take && pend_v_q) pend_v_d = 1'b0;
    if (fire && !(take && !pend_v_q) && (!pend_v_q || take)) begin
      pend_v_d = 1'b1; pend_addr_d = addr; pend_rw_d = rw; pend_data_d = data_in;
    end

    state_d = state_q; ctrl_d = ctrl_q; line_d = line_q; ptr_d = ptr_q; sel_d = sel_q;
    inc_d = inc_q; rdbuf_d = rdbuf_q; wdata_d = wdata_q; dout_d = dout_q; clr = 2'b00;
    case (state_q)
      S_IDLE: if (take) begin
        if (a_rw) begin
          dout_d = rd_val;
          if (a_addr == 4'd7) begin
            ptr_d   = ptr_q + ADDR_W'(inc_q);
            state_d = S_PREFETCH;
          end
        end else begin
          case (a_addr)
            4'd0: ctrl_d = a_data[1:0];
            4'd1: clr = a_data[1:0];
            4'd2: line_d[7:0] = a_data;
            4'd3: line_d[SCANLINE_W-1:8] = a_data[SCANLINE_W-9:0];
            4'd4: begin ptr_d[7:0] = a_data; state_d = S_PREFETCH; end
            4'd5: begin ptr_d[ADDR_W-1:8] = a_data[ADDR_W-9:0]; state_d = S_PREFETCH; end
            4'd6: begin
              if (a_data < NUM_MEM_B) sel_d = a_data[2:0];
              state_d = S_PREFETCH;
            end
            4'd7: begin wdata_d = a_data; state_d = S_WRITE; end
            4'd8: inc_d = a_data;
            default: ;
          endcase
        end
      end
      S_WRITE: begin
        ptr_d   = ptr_q + ADDR_W'(inc_q);
        state_d = S_PREFETCH;
      end
      S_PREFETCH: state_d = S_WAIT;
      S_WAIT: begin
        rdbuf_d = rdata_sel;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a new event in the same cycle as a STATUS clear wins
    set[0] = vblank & ~vb_prev_q;
    set[1] = (scanline != scan_prev_q) && (scanline == line_q);
    irqp_d = (irqp_q & ~clr) | set;
  end

  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      sync_q <= '1; cs_prev_q <= 1'b1;
      state_q <= S_IDLE;
      pend_v_q <= 1'b0; pend_rw_q <= 1'b0; pend_addr_q <= '0; pend_data_q <= '0;
      ctrl_q <= '0; irqp_q <= '0; line_q <= '0; ptr_q <= '0; sel_q <= '0;
      inc_q <= '0; rdbuf_q <= '0; wdata_q <= '0; dout_q <= '0;
      vb_prev_q <= 1'b0; scan_prev_q <= '0; irq_q <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], cs_clock};
      else sync_q <= cs_clock;
      cs_prev_q <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      pend_v_q <= pend_v_d; pend_rw_q <= pend_rw_d; pend_addr_q <= pend_addr_d; pend_data_q <= pend_data_d;
      ctrl_q <= ctrl_d; irqp_q <= irqp_d; line_q <= line_d; ptr_q <= ptr_d; sel_q <= sel_d;
      inc_q <= inc_d; rdbuf_q <= rdbuf_d; wdata_q <= wdata_d; dout_q <= dout_d;
      vb_prev_q <= vblank; scan_prev_q <= scanline;
      irq_q <= |(irqp_q & ctrl_q);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MEM; i++) begin
      mem_we[i]    = (state_q == S_WRITE)    && (sel_q == 3'(i));
      mem_rd_en[i] = (state_q == S_PREFETCH) && (sel_q == 3'(i));
    end
  end

  assign mem_addr  = ptr_q;
  assign mem_wdata = wdata_q;
  assign data_out  = dout_q;
  assign data_oe   = cs_clock & rw;
  assign irq       = irq_q;
endmodule

// File: tb/tb_gpu_host_port.sv
// Bench for gpu_host_port: vector table of bus accesses, memory-write scoreboard, IRQ/reset sequences.
module tb_gpu_host_port;
  localparam int NUM_MEM = 3, ADDR_W = 12, SCANLINE_W = 9, SYNC_STAGES = 2;

  logic clk = 0, rst = 1;
  logic [7:0] data_in = 0, data_out;
  logic data_oe, rw = 0, cs_clock = 0, vblank = 0, irq;
  logic [3:0] addr = 0;
  logic [SCANLINE_W-1:0] scanline = 0;
  logic [NUM_MEM-1:0] mem_we, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [NUM_MEM*8-1:0] mem_rdata;

  gpu_host_port #(.NUM_MEM(NUM_MEM), .ADDR_W(ADDR_W), .SCANLINE_W(SCANLINE_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK100MHz(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .addr(addr), .rw(rw), .cs_clock(cs_clock), .scanline(scanline), .vblank(vblank),
    .mem_we(mem_we), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .irq(irq));

  always #5 clk = ~clk;

  int checks = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // memory model: 1-cycle read latency
  logic [7:0] mem [NUM_MEM][4096];
  logic [7:0] rdq [NUM_MEM];
  always @(posedge clk)
    for (int i = 0; i < NUM_MEM; i++) begin
      if (mem_we[i]) mem[i][mem_addr] <= mem_wdata;
      if (mem_rd_en[i]) rdq[i] <= mem[i][mem_addr];
    end
  always_comb for (int i = 0; i < NUM_MEM; i++) mem_rdata[i*8 +: 8] = rdq[i];

  typedef struct { logic [2:0] sel; logic [11:0] a; logic [7:0] d; } wr_t;
  wr_t sbq[$];
  logic [NUM_MEM-1:0] last_rd_en = 0;
  logic [ADDR_W-1:0]  last_rd_addr = 0;

  always @(negedge clk) begin
    if (|mem_rd_en) begin last_rd_en = mem_rd_en; last_rd_addr = mem_addr; end
    if (!rst && mem_we != 0) begin
      wr_t e;
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_we: we=%b addr=0x%0h data=0x%0h expected none", mem_we, mem_addr, mem_wdata);
      end else begin
        e = sbq.pop_front();
        if (mem_we !== 3'(1 << e.sel) || mem_addr !== e.a || mem_wdata !== e.d) begin
          fails++;
          $display("FAIL mem_write: got we=%b addr=0x%0h data=0x%0h expected sel=%0d addr=0x%0h data=0x%0h",
                   mem_we, mem_addr, mem_wdata, e.sel, e.a, e.d);
        end
      end
    end
  end

  typedef struct {
    logic [3:0] a; logic rw; logic [7:0] d; logic chk; logic [7:0] exp;
    logic we; logic [2:0] we_sel; logic [11:0] we_addr;
    logic rdchk; logic [11:0] rd_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic W(input logic [3:0] a, input logic [7:0] d);
    vecs.push_back('{a, 1'b0, d, 1'b0, 8'h0, 1'b0, 3'd0, 12'h0, 1'b0, 12'h0});
  endtask
  task automatic R(input logic [3:0] a, input logic [7:0] exp);
    vecs.push_back('{a, 1'b1, 8'h0, 1'b1, exp, 1'b0, 3'd0, 12'h0, 1'b0, 12'h0});
  endtask
  task automatic WD(input logic [7:0] d, input logic [2:0] s, input logic [11:0] wa,
                    input logic rc, input logic [11:0] ra);
    vecs.push_back('{4'd7, 1'b0, d, 1'b0, 8'h0, 1'b1, s, wa, rc, ra});
  endtask

  task automatic access(input logic [3:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    addr = a; rw = r; data_in = d; cs_clock = 1;
    repeat (8) @(negedge clk);
    cs_clock = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
    access(a, 1'b1, 8'h0);
    chk(name, data_out, exp);
  endtask

  int rises;
  logic irq_prev;

  initial begin
    mem[0][0] = 8'hE1; mem[0][16] = 8'h3C; mem[0][17] = 8'hC3;

    W(8, 8'h05); R(8, 8'h05); R(12, 8'h00); R(0, 8'h00); R(1, 8'h00);
    W(6, 8'h01); W(4, 8'hFF); W(5, 8'h00); W(8, 8'h01);
    WD(8'hAA, 1, 12'h0FF, 0, 0); WD(8'h55, 1, 12'h100, 0, 0);
    R(4, 8'h01); R(5, 8'h01); R(6, 8'h01);
    W(4, 8'hFF); W(5, 8'hFF); R(5, 8'h0F); W(8, 8'h02);
    WD(8'h77, 1, 12'hFFF, 1, 12'h001);
    R(4, 8'h01); R(5, 8'h00);
    W(6, 8'h00); W(4, 8'h10); W(5, 8'h00); W(8, 8'h01);
    R(7, 8'h3C); R(7, 8'hC3); R(4, 8'h12);
    W(6, 8'h01); W(4, 8'hFF); W(5, 8'h00); R(7, 8'hAA); R(7, 8'h55);
    W(2, 8'h05); W(3, 8'hFF); R(3, 8'h01); W(3, 8'h01); R(2, 8'h05);
    W(9, 8'h33); R(9, 8'h00);

    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("reset_data_out", data_out, 0);
    chk("reset_irq", irq, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_rd_en", mem_rd_en, 0);
    chk("reset_data_oe", data_oe, 0);

    foreach (vecs[i]) begin
      if (vecs[i].we) sbq.push_back('{vecs[i].we_sel, vecs[i].we_addr, vecs[i].d});
      access(vecs[i].a, vecs[i].rw, vecs[i].d);
      if (vecs[i].chk) chk($sformatf("vec%0d_rd", i), data_out, vecs[i].exp);
      if (vecs[i].rdchk) begin
        chk($sformatf("vec%0d_pref_addr", i), last_rd_addr, vecs[i].rd_addr);
        chk($sformatf("vec%0d_pref_en", i), last_rd_en, 3'(1 << vecs[i].we_sel));
      end
    end

    // data_oe follows cs_clock & rw
    @(negedge clk); addr = 0; rw = 1; cs_clock = 1; #1;
    chk("data_oe_read", data_oe, 1);
    repeat (8) @(negedge clk); cs_clock = 0; repeat (4) @(negedge clk);

    // vblank IRQ
    access(0, 0, 8'h01);
    @(negedge clk) vblank = 1;
    repeat (3) @(negedge clk);
    chk("vb_irq_set", irq, 1);
    rd("vb_status", 1, 8'h81);
    access(1, 0, 8'h01);
    chk("vb_irq_clr", irq, 0);
    rd("vb_status_clr", 1, 8'h80);
    vblank = 0; repeat (2) @(negedge clk); vblank = 1; repeat (3) @(negedge clk);
    chk("vb_irq_again", irq, 1);
    access(0, 0, 8'h00);
    chk("vb_irq_disabled", irq, 0);
    rd("vb_pend_kept", 1, 8'h81);
    access(0, 0, 8'h01);
    chk("vb_irq_reenabled", irq, 1);
    access(1, 0, 8'h01);
    vblank = 0; repeat (3) @(negedge clk);
    chk("vb_irq_cleared2", irq, 0);
    // vblank edge lands on the same cycle as the STATUS clear
    @(negedge clk); addr = 1; rw = 0; data_in = 8'h01; cs_clock = 1;
    @(posedge clk); @(posedge clk); #1 vblank = 1;
    repeat (8) @(negedge clk); cs_clock = 0; repeat (4) @(negedge clk);
    chk("vb_set_wins_irq", irq, 1);
    rd("vb_set_wins_status", 1, 8'h81);
    access(1, 0, 8'h01);
    vblank = 0; repeat (3) @(negedge clk);
    access(0, 0, 8'h00);

    // scanline match IRQ
    access(2, 0, 8'h05); access(3, 0, 8'h01); access(0, 0, 8'h02); access(1, 0, 8'h03);
    chk("line_irq_idle", irq, 0);
    rises = 0; irq_prev = irq;
    for (int s = 0; s < 512; s++) begin
      @(negedge clk);
      if (irq && !irq_prev) rises++;
      irq_prev = irq;
      scanline = 9'(s);
    end
    repeat (3) @(negedge clk) begin if (irq && !irq_prev) rises++; irq_prev = irq; end
    chk("line_irq_rises", rises, 1);
    rd("line_status", 1, 8'h02);
    access(1, 0, 8'h02);
    chk("line_irq_clr", irq, 0);
    access(0, 0, 8'h00);
    access(6, 0, 8'h07);
    rd("sel_ignored", 6, 8'h01);

    // cs_clock held high through reset release
    @(negedge clk); addr = 7; rw = 0; data_in = 8'h99; cs_clock = 1; rst = 1;
    repeat (2) @(negedge clk); rst = 0;
    repeat (10) @(negedge clk);
    chk("cs_hold_we", mem_we, 0);
    chk("cs_hold_data_out", data_out, 0);
    chk("cs_hold_irq", irq, 0);
    cs_clock = 0; repeat (4) @(negedge clk);

    // reset while in WRITE
    @(negedge clk); addr = 7; rw = 0; data_in = 8'h5A; cs_clock = 1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1 rst = 1; #1;
    chk("midwr_mem_we", mem_we, 0);
    chk("midwr_mem_rd_en", mem_rd_en, 0);
    chk("midwr_data_out", data_out, 0);
    chk("midwr_irq", irq, 0);
    repeat (2) @(negedge clk); rst = 0;
    repeat (10) @(negedge clk); cs_clock = 0; repeat (4) @(negedge clk);
    access(4, 0, 8'h00);
    rd("midwr_mem_intact", 7, 8'hE1);
    rd("midwr_sel_reset", 6, 8'h00);

    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
